// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
//   arb_state_e    : two-state arbiter FSM encoding (ST_IDLE / ST_BURST)
//   DEFAULT_DATA_W : byte-wide data path shared with the FIFO data_in
//   grant_w()      : width of a producer index for a given producer count
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned DEFAULT_DATA_W = 8;

  // Never returns 0 so a single-bit index remains legal for degenerate counts.
  function automatic int unsigned grant_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the producer streams and the FIFO write port around the arbiter.
//   req_valid/req_last/req_data : producer streams, producer i data at [i*DATA_W +: DATA_W]
//   req_ready                   : per-producer accept, one-hot or zero
//   fifo_full                   : FIFO full flag (programmable threshold)
//   fifo_wr_en/fifo_data        : FIFO write_enable / data_in
// Modports: master = the arbiter (drives accepts and the FIFO write port),
//           slave  = producers plus FIFO (drive streams and full).
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_data;

  modport master (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  fifo_full,
    output req_ready,
    output fifo_wr_en,
    output fifo_data
  );

  modport slave (
    output req_valid,
    output req_last,
    output req_data,
    output fifo_full,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: returns the first asserted request searching
// ptr, ptr+1, ... wrapping modulo NUM_REQ. Purely combinational.
//   req   : request vector
//   ptr   : search start index (must be < NUM_REQ)
//   found : any request asserted
//   index : chosen request index (0 when found is low)
module rr_pick import fifo_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               found,
  output logic [GRANT_W-1:0] index
);

  logic               hit_hi;
  logic [GRANT_W-1:0] idx_hi;
  logic [GRANT_W-1:0] idx_lo;

  // Lowest request at or above ptr wins; otherwise wrap to the lowest request
  // overall. Scanning downward leaves the lowest match in each variable.
  always_comb begin
    hit_hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = GRANT_W'(i);
        if (GRANT_W'(i) >= ptr) begin
          hit_hi = 1'b1;
          idx_hi = GRANT_W'(i);
        end
      end
    end
  end

  assign found = |req;
  assign index = hit_hi ? idx_hi : idx_lo;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO among NUM_REQ producers.
// A grant is held for a packet-locked burst that ends on a last beat or after
// MAX_BURST beats; one IDLE cycle separates bursts.
//   clock    : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : producer streams and FIFO write port (master modport)
//   grant_id : index of the current or most recently granted producer
//   busy     : high while a burst grant is held
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter  int unsigned MAX_BURST = 8,
  localparam int unsigned GRANT_W   = grant_w(NUM_REQ),
  localparam int unsigned BEAT_W    = $clog2(MAX_BURST) + 1
) (
  input  logic                clock,
  input  logic                reset_n,
  fifo_wr_arbiter_if.master   bus,
  output logic [GRANT_W-1:0]  grant_id,
  output logic                busy
);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;

  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;

  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic               transfer;
  logic               burst_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  // Stream of the granted producer.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // reset_n gating keeps the reset cycle write-free even mid-burst.
  assign transfer  = reset_n && (state_q == ST_BURST) && sel_valid && !bus.fifo_full;
  assign burst_end = transfer && (sel_last || (beat_q == BEAT_W'(MAX_BURST - 1)));

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (burst_end) begin
          state_d  = ST_IDLE;
          beat_d   = '0;
          rr_ptr_d = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end else if (transfer) begin
          beat_d = beat_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs. Ready follows only ~fifo_full so a stalled producer can still see
  // the grant; the write itself additionally needs valid.
  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_wr_en = 1'b0;
    bus.fifo_data  = sel_data;
    if (reset_n && (state_q == ST_BURST)) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == GRANT_W'(i)) begin
          bus.req_ready[i] = !bus.fifo_full;
        end
      end
      bus.fifo_wr_en = transfer;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ST_BURST);

  ready_onehot_a: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(bus.req_ready));

  beat_bound_a: assert property (@(posedge clock) disable iff (!reset_n)
    beat_q < BEAT_W'(MAX_BURST));

  wr_needs_room_a: assert property (@(posedge clock) disable iff (!reset_n)
    bus.fifo_wr_en |-> !bus.fifo_full && busy);

endmodule
